// File: rtl/fetch_stage_if.sv
// Instruction-memory request/response bundle between the fetch stage and imem.
//
// Handshake: the master raises imem_req with a stable imem_addr and keeps both
// unchanged until the slave returns imem_done=1 together with imem_data. The
// transfer completes on the rising edge that samples imem_req=1 and
// imem_done=1. The slave may assert imem_done in the first request cycle.
// There is no backpressure on the response.
interface fetch_stage_if;
  logic        imem_req;
  logic [15:0] imem_addr;
  logic [15:0] imem_data;
  logic        imem_done;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_data,
    input  imem_done
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_data,
    output imem_done
  );
endinterface

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC, issues imem reads, fills the IF/ID
// register, parks one instruction in a skid buffer across hazard stalls,
// squashes wrong-path responses after a redirect and freezes on HALT.
module fetch_stage #(
  parameter logic [15:0] RESET_PC = 16'h0000,
  parameter logic [15:0] NOP_INST = 16'h0800
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 pcNop,
  input  logic                 redirect,
  input  logic [15:0]          redirectPC,
  fetch_stage_if.master        imem,
  output logic [15:0]          fetch_inst,
  output logic [15:0]          fetch_pc2,
  output logic                 fetch_valid,
  output logic                 halted,
  output logic [2:0]           dbgState
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    FETCH  = 3'd1,
    HOLD   = 3'd2,
    SQUASH = 3'd3,
    HALT   = 3'd4
  } state_t;

  state_t      state;
  logic [15:0] pc;
  logic [15:0] reqAddr;
  logic [15:0] bufInst;
  logic [15:0] bufPc2;
  logic        bufValid;

  logic [15:0] pcPlus2;
  logic        dataIsHalt;
  logic        bufIsHalt;
  logic        inFlight;

  // Next-PC and opcode decodes used by the state register below.
  always_comb begin
    pcPlus2    = pc + 16'd2;
    dataIsHalt = (imem.imem_data[15:11] == 5'b00000);
    bufIsHalt  = (bufInst[15:11] == 5'b00000);
    inFlight   = (state == FETCH) || (state == SQUASH);
  end

  // Request and status outputs come only from registered state.
  assign imem.imem_req  = inFlight;
  assign imem.imem_addr = reqAddr;
  assign halted         = (state == HALT);
  assign dbgState       = state;

  // Single state register: PC, request address, IF/ID and skid buffer.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= IDLE;
      pc          <= RESET_PC;
      reqAddr     <= RESET_PC;
      fetch_inst  <= NOP_INST;
      fetch_pc2   <= 16'h0000;
      fetch_valid <= 1'b0;
      bufInst     <= NOP_INST;
      bufPc2      <= 16'h0000;
      bufValid    <= 1'b0;
    end else if (state == IDLE) begin
      reqAddr <= pc;
      state   <= FETCH;
    end else if (redirect) begin
      // Redirect beats pcNop; a still-pending read must drain before the
      // new target can be requested, so its address is left untouched.
      pc          <= redirectPC;
      fetch_inst  <= NOP_INST;
      fetch_pc2   <= 16'h0000;
      fetch_valid <= 1'b0;
      bufInst     <= NOP_INST;
      bufPc2      <= 16'h0000;
      bufValid    <= 1'b0;
      if (inFlight && !imem.imem_done) begin
        state <= SQUASH;
      end else begin
        reqAddr <= redirectPC;
        state   <= FETCH;
      end
    end else begin
      case (state)
        FETCH: begin
          if (imem.imem_done) begin
            pc <= pcPlus2;
            if (!pcNop) begin
              fetch_inst  <= imem.imem_data;
              fetch_pc2   <= pcPlus2;
              fetch_valid <= 1'b1;
              reqAddr     <= pcPlus2;
              state       <= dataIsHalt ? HALT : FETCH;
            end else begin
              bufInst  <= imem.imem_data;
              bufPc2   <= pcPlus2;
              bufValid <= 1'b1;
              state    <= HOLD;
            end
          end else if (!pcNop) begin
            fetch_inst  <= NOP_INST;
            fetch_pc2   <= 16'h0000;
            fetch_valid <= 1'b0;
          end
        end
        HOLD: begin
          if (!pcNop) begin
            fetch_inst  <= bufInst;
            fetch_pc2   <= bufPc2;
            fetch_valid <= 1'b1;
            bufInst     <= NOP_INST;
            bufPc2      <= 16'h0000;
            bufValid    <= 1'b0;
            reqAddr     <= pc;
            state       <= bufIsHalt ? HALT : FETCH;
          end
        end
        SQUASH: begin
          if (imem.imem_done) begin
            reqAddr <= pc;
            state   <= FETCH;
          end
        end
        default: begin
          // HALT: everything frozen until a redirect.
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: streaming, stall with skid buffer, HALT,
// redirect out of HALT, redirect during a slow read, redirect/stall priority
// with PC wrap, and asynchronous reset.
module tb_fetch_stage;

  localparam logic [15:0] NOP = 16'h0800;
  localparam logic [2:0]  ST_IDLE   = 3'd0;
  localparam logic [2:0]  ST_FETCH  = 3'd1;
  localparam logic [2:0]  ST_HOLD   = 3'd2;
  localparam logic [2:0]  ST_SQUASH = 3'd3;

  // Clock and reset
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic        pcNop = 1'b0;
  logic        redirect = 1'b0;
  logic [15:0] redirectPC = 16'h0000;
  logic        done = 1'b0;
  logic [15:0] fetch_inst;
  logic [15:0] fetch_pc2;
  logic        fetch_valid;
  logic        halted;
  logic [2:0]  dbgState;

  // Instruction memory: word i holds 16'h1000|i, except address 6 holds HALT.
  logic [15:0] mem [256];

  fetch_stage_if bus ();
  assign bus.imem_data = mem[bus.imem_addr[8:1]];
  assign bus.imem_done = done;

  fetch_stage #(.RESET_PC(16'h0000), .NOP_INST(NOP)) dut (
    .clk        (clk),
    .rst        (rst),
    .pcNop      (pcNop),
    .redirect   (redirect),
    .redirectPC (redirectPC),
    .imem       (bus.master),
    .fetch_inst (fetch_inst),
    .fetch_pc2  (fetch_pc2),
    .fetch_valid(fetch_valid),
    .halted     (halted),
    .dbgState   (dbgState)
  );

  int errors = 0;
  int checks = 0;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Advance one clock; inputs change and outputs are sampled 1 ns after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_req"},   16'(bus.imem_req), 16'h0000);
    chk({tag, "_addr"},  bus.imem_addr,     16'h0000);
    chk({tag, "_inst"},  fetch_inst,        NOP);
    chk({tag, "_pc2"},   fetch_pc2,         16'h0000);
    chk({tag, "_valid"}, 16'(fetch_valid),  16'h0000);
    chk({tag, "_halt"},  16'(halted),       16'h0000);
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 16'h1000 | 16'(i);
    mem[3] = 16'h0000;

    // Reset state
    tick();
    tick();
    chk_reset_vals("rst");
    chk("rst_state", 16'(dbgState), 16'(ST_IDLE));

    // Streaming with done tied high
    rst  = 1'b1;
    done = 1'b1;
    tick();
    chk("first_req", 16'(bus.imem_req), 16'h0001);
    chk("addr0", bus.imem_addr, 16'h0000);
    chk("first_valid", 16'(fetch_valid), 16'h0000);
    tick();
    chk("addr2", bus.imem_addr, 16'h0002);
    chk("inst0", fetch_inst, 16'h1000);
    chk("pc2_0", fetch_pc2, 16'h0002);
    chk("valid0", 16'(fetch_valid), 16'h0001);
    tick();
    chk("addr4", bus.imem_addr, 16'h0004);
    chk("inst1", fetch_inst, 16'h1001);
    chk("pc2_1", fetch_pc2, 16'h0004);

    // Stall for 3 cycles while address 4 completes
    pcNop = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("stall_req", 16'(bus.imem_req), 16'h0000);
      chk("stall_inst", fetch_inst, 16'h1001);
      chk("stall_pc2", fetch_pc2, 16'h0004);
      chk("stall_state", 16'(dbgState), 16'(ST_HOLD));
    end
    pcNop = 1'b0;
    tick();
    chk("unstall_inst", fetch_inst, 16'h1002);
    chk("unstall_pc2", fetch_pc2, 16'h0006);
    chk("unstall_valid", 16'(fetch_valid), 16'h0001);
    chk("unstall_req", 16'(bus.imem_req), 16'h0001);
    chk("unstall_addr", bus.imem_addr, 16'h0006);

    // HALT fetched from address 6
    tick();
    chk("halt_inst", fetch_inst, 16'h0000);
    chk("halt_pc2", fetch_pc2, 16'h0008);
    chk("halt_flag", 16'(halted), 16'h0001);
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("halt_noreq", 16'(bus.imem_req), 16'h0000);
      chk("halt_frozen", fetch_inst, 16'h0000);
    end

    // Redirect out of HALT to 0x0020
    redirect   = 1'b1;
    redirectPC = 16'h0020;
    tick();
    redirect = 1'b0;
    chk("unhalt_flag", 16'(halted), 16'h0000);
    chk("unhalt_req", 16'(bus.imem_req), 16'h0001);
    chk("unhalt_addr", bus.imem_addr, 16'h0020);
    chk("unhalt_valid", 16'(fetch_valid), 16'h0000);
    chk("unhalt_inst", fetch_inst, NOP);
    tick();
    chk("f20_inst", fetch_inst, 16'h1010);
    chk("f20_pc2", fetch_pc2, 16'h0022);
    chk("f20_addr", bus.imem_addr, 16'h0022);

    // Latency-4 read of 0x22, redirect to 0x0100 on the second wait cycle
    done = 1'b0;
    tick();
    chk("miss_addr1", bus.imem_addr, 16'h0022);
    chk("miss_bubble", 16'(fetch_valid), 16'h0000);
    chk("miss_inst", fetch_inst, NOP);
    redirect   = 1'b1;
    redirectPC = 16'h0100;
    tick();
    redirect = 1'b0;
    chk("sq_req", 16'(bus.imem_req), 16'h0001);
    chk("sq_addr", bus.imem_addr, 16'h0022);
    chk("sq_state", 16'(dbgState), 16'(ST_SQUASH));
    tick();
    chk("sq_addr2", bus.imem_addr, 16'h0022);
    done = 1'b1;
    tick();
    chk("sq_drop_valid", 16'(fetch_valid), 16'h0000);
    chk("sq_drop_inst", fetch_inst, NOP);
    chk("sq_new_addr", bus.imem_addr, 16'h0100);
    chk("sq_new_state", 16'(dbgState), 16'(ST_FETCH));
    tick();
    chk("f100_inst", fetch_inst, 16'h1080);
    chk("f100_pc2", fetch_pc2, 16'h0102);

    // pcNop and redirect together, target 0xFFFE, then wrap
    pcNop      = 1'b1;
    redirect   = 1'b1;
    redirectPC = 16'hFFFE;
    tick();
    pcNop    = 1'b0;
    redirect = 1'b0;
    chk("prio_valid", 16'(fetch_valid), 16'h0000);
    chk("prio_inst", fetch_inst, NOP);
    chk("prio_addr", bus.imem_addr, 16'hFFFE);
    tick();
    chk("wrap_inst", fetch_inst, 16'h10FF);
    chk("wrap_pc2", fetch_pc2, 16'h0000);
    chk("wrap_addr", bus.imem_addr, 16'h0000);
    tick();
    chk("wrap_inst2", fetch_inst, 16'h1000);
    chk("wrap_pc2b", fetch_pc2, 16'h0002);

    // Asynchronous reset between edges while a read is pending
    done = 1'b0;
    #3;
    rst = 1'b0;
    #1;
    chk_reset_vals("arst");
    tick();
    rst = 1'b1;
    tick();
    chk("rerun_req", 16'(bus.imem_req), 16'h0001);
    chk("rerun_addr", bus.imem_addr, 16'h0000);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Hard time limit so the run always ends.
  initial begin
    #100000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/fetch_stage.md
# fetch_stage

Instruction-fetch stage of the pipelined WISC core. It owns the PC, requests instructions from a variable-latency instruction memory, and drives the IF/ID pipeline register that the hazard detector reads as its fetched instruction. It holds on hazard stalls (`pcNop`), squashes wrong-path fetches on redirect, and freezes on HALT.

## Interface
- `RESET_PC`, default 16'h0000: PC loaded at reset.
- `NOP_INST`, default 16'h0800: bubble encoding placed in IF/ID.
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst`  in  1  asynchronous, active-low reset (asserted when 0).
- `pcNop`  in  1  hazard stall from the hazard detector: hold PC and IF/ID.
- `redirect`  in  1  taken branch or jump resolved downstream.
- `redirectPC`  in  16  target PC, valid with `redirect`.
- `imem_req`  out  1  instruction read request.
- `imem_addr`  out  16  request address; stable while `imem_req` is high until `imem_done`.
- `imem_data`  in  16  instruction, valid when `imem_done`=1.
- `imem_done`  in  1  response strobe. Legal any cycle `imem_req`=1, including the first request cycle.
- `fetch_inst`  out  16  IF/ID instruction, registered.
- `fetch_pc2`  out  16  PC+2 of `fetch_inst`, registered.
- `fetch_valid`  out  1  IF/ID holds a real instruction (0 = bubble).
- `halted`  out  1  the fetch stage is in HALT.

## Operation
- Registers:
  - `pc`: next address to fetch.
  - `req_addr`: drives `imem_addr`.
  - IF/ID: `fetch_inst`, `fetch_pc2`, `fetch_valid`.
  - One-entry skid buffer: instruction and PC+2.
  - State register.
- States: IDLE, FETCH, HOLD, SQUASH, HALT. `imem_req`=1 only in FETCH and SQUASH.
- **IDLE** (reset state): go to FETCH on the first clock after reset release. Load `req_addr`=`pc`.
- **FETCH**, with `imem_done`=1 and no redirect:
  - If `pcNop`=0: IF/ID <= {`imem_data`, `pc`+2, valid=1}. Then `pc` <= `pc`+2 and `req_addr` <= `pc`+2.
  - If `pcNop`=1: buffer <= {`imem_data`, `pc`+2}. Then `pc` <= `pc`+2 and the state goes to HOLD. IF/ID is unchanged.
  - If the accepted opcode [15:11] is 5'b00000 (HALT): the state goes to HALT instead of staying in FETCH. A buffered HALT goes to HOLD first.
- **FETCH**, with `imem_done`=0:
  - If `pcNop`=0: IF/ID <= {`NOP_INST`, 0, valid=0}.
  - If `pcNop`=1: IF/ID holds.
- **HOLD**:
  - While `pcNop`=1: hold.
  - When `pcNop`=0: IF/ID <= buffer with valid=1, and the buffer is cleared. Go to HALT if the buffered instruction is HALT; otherwise go to FETCH with `req_addr`=`pc`.
- **SQUASH**:
  - Keep `imem_req`=1 with the old `req_addr` until `imem_done`.
  - On `imem_done`, discard the data, set `req_addr` <= `pc`, and go to FETCH.
  - IF/ID stays a bubble.
- **HALT**: no requests; `pc` and IF/ID are frozen. `halted`=1.
- **Redirect** has the highest priority, over `pcNop` and in every state except IDLE:
  - `pc` <= `redirectPC`, IF/ID <= bubble, and the buffer is cleared.
  - From FETCH with `imem_done`=0: go to SQUASH. `req_addr` is unchanged.
  - From FETCH with `imem_done`=1, or from HOLD or HALT: go to FETCH with `req_addr` <= `redirectPC`. Data returned in that cycle is discarded.
  - From SQUASH with `imem_done`=0: stay in SQUASH and update `pc`.
  - From SQUASH with `imem_done`=1: go to FETCH at `redirectPC`.
- PC arithmetic is 16-bit modulo: 16'hFFFE + 2 wraps to 16'h0000.

## Timing
- Reset values (async, while `rst`=0):
  - State IDLE, `imem_req`=0.
  - `pc`=`req_addr`=`RESET_PC`.
  - `fetch_inst`=`NOP_INST`, `fetch_pc2`=0, `fetch_valid`=0.
  - `halted`=0, buffer empty.
- First request: `imem_req` rises one cycle after `rst` deasserts.
- Fetch latency: `fetch_inst` updates on the edge that samples `imem_done`. It is visible the next cycle.
- Peak throughput is one instruction per cycle, when `imem_done` asserts in the first request cycle.
- `imem_req`, `imem_addr` and `halted` are decoded from registers only. They have no combinational path from `pcNop`, `redirect` or `imem_done`.
- Simultaneous `pcNop` and `redirect`: redirect wins.
- Reset mid-request: the outstanding response is abandoned and the memory must tolerate the dropped request.

## Test plan
- **Streaming:** reset with `RESET_PC`=0 and `imem_done` tied to 1. Required response:
  - `imem_addr` sequences 0, 2, 4.
  - `fetch_inst` follows the memory words one cycle later, with `fetch_valid`=1 and `fetch_pc2` = 2, 4, 6.
- **Stall with buffer:** assert `pcNop` for 3 cycles while the fetch of address 4 completes. Required response:
  - IF/ID holds the address-2 instruction during the stall.
  - `imem_req`=0 in HOLD.
  - On release, `fetch_inst` = mem[4] and `fetch_pc2`=6, then fetching continues at 6.
- **Redirect during outstanding miss:** memory latency 4. Assert `redirect` with `redirectPC`=16'h0100 at the second wait cycle. Required response:
  - `imem_addr` stays on the old address until `imem_done`.
  - The returned data never reaches IF/ID.
  - The next request is to 0x0100.
- **HALT:** memory returns 16'h0000 at address 6. Required response:
  - `fetch_inst`=16'h0000, `halted`=1 the next cycle.
  - `imem_req` stays 0 for 10 cycles.
  - A later redirect to 0x0020 clears `halted` and fetches 0x0020.
- **Priority and wrap:** `pcNop` and `redirect` both high with `redirectPC`=16'hFFFE. Required response:
  - IF/ID becomes a bubble.
  - Fetches go 0xFFFE, then 0x0000.
- **Async reset:** pull `rst` low mid-request, between clock edges. Required response: all outputs take their reset values immediately, without a clock edge.
